seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with tear-free word updates.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
    parameter int DIV  = 100000,
    parameter int DEAD = 16,
    parameter int CW   = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_mask,
    output logic [1:0]  digit_sel,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        pending,
    output logic        frame_tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pend_reg_q, pend_reg_d;
    logic          pending_q, pending_d;
    logic [1:0]    digit_sel_q, digit_sel_d;
    logic [3:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;
    logic          frame_tick_q, frame_tick_d;

    logic          last;
    logic          boundary;
    logic          dead;
    logic          lz_blank;
    logic [3:0]    nib;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        unique case (n)
            4'h0: f = 7'b1000000;
            4'h1: f = 7'b1111001;
            4'h2: f = 7'b0100100;
            4'h3: f = 7'b0110000;
            4'h4: f = 7'b0011001;
            4'h5: f = 7'b0010010;
            4'h6: f = 7'b0000010;
            4'h7: f = 7'b1111000;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0010000;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b0000011;
            4'hC: f = 7'b1000110;
            4'hD: f = 7'b0100001;
            4'hE: f = 7'b0000110;
            4'hF: f = 7'b0001110;
        endcase
        return f;
    endfunction

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pend_reg_d   = pend_reg_q;
        pending_d    = pending_q;
        digit_sel_d  = 2'd0;
        an_n_d       = 4'b1111;
        seg_n_d      = 7'b1111111;
        dp_n_d       = 1'b1;
        frame_tick_d = 1'b0;

        last     = (cnt_q == CNT_LAST);
        boundary = en && last && (idx_q == 2'd3);
        dead     = (cnt_q < DEAD_C);
        nib      = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
        unique case (idx_q)
            2'd0: lz_blank = 1'b0;
            2'd1: lz_blank = (shadow_q[15:4] == 12'd0);
            2'd2: lz_blank = (shadow_q[15:8] == 8'd0);
            2'd3: lz_blank = (shadow_q[15:12] == 4'd0);
        endcase
`else
        lz_blank = 1'b0;
`endif

        if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (last) begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            cnt_d = '0;
            idx_d = 2'd0;
        end

        // A load landing on the boundary bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                shadow_d = data;
            end else if (pending_q) begin
                shadow_d = pend_reg_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pend_reg_d = data;
            pending_d  = 1'b1;
        end

        if (en) begin
            digit_sel_d  = idx_q;
            frame_tick_d = boundary;
            if (!dead) begin
                an_n_d  = ~(4'b0001 << idx_q);
                seg_n_d = lz_blank ? 7'b1111111 : font(nib);
                dp_n_d  = ~dp_mask[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'd0;
            pend_reg_q   <= 16'd0;
            pending_q    <= 1'b0;
            digit_sel_q  <= 2'd0;
            an_n_q       <= 4'b1111;
            seg_n_q      <= 7'b1111111;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pend_reg_q   <= pend_reg_d;
            pending_q    <= pending_d;
            digit_sel_q  <= digit_sel_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based display model predicts every cycle.
// Honours SEG7_LZ_BLANK_EN the same way the design does.
module tb_seg7_scan_ctrl;

    localparam int DIV  = 8;
    localparam int DEAD = 2;

    typedef struct packed {
        logic [1:0] ds;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pend;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [1:0]  digit_sel;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        pending;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;
    exp_t q[$];

    logic [6:0] font_tb [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: time since scan (re)start, plus the display buffers.
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_pend;
    logic        m_pending;

    seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD), .CW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .data       (data),
        .dp_mask    (dp_mask),
        .digit_sel  (digit_sel),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t o;
        o.ds   = digit_sel;
        o.an   = an_n;
        o.seg  = seg_n;
        o.dp   = dp_n;
        o.pend = pending;
        o.tick = frame_tick;
        return o;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            exp_t o;
            e = q.pop_front();
            o = observed();
            popped++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cycle%0d got ds=%0d an=%b seg=%b dp=%b pend=%b tick=%b expected ds=%0d an=%b seg=%b dp=%b pend=%b tick=%b",
                         popped, o.ds, o.an, o.seg, o.dp, o.pend, o.tick,
                         e.ds, e.an, e.seg, e.dp, e.pend, e.tick);
            end
        end
    end

    function automatic int slot_now();
        return (m_t / DIV) % 4;
    endfunction

    function automatic int phase_now();
        return m_t % DIV;
    endfunction

    task automatic model_reset();
        m_t       = 0;
        m_shadow  = 16'd0;
        m_pend    = 16'd0;
        m_pending = 1'b0;
    endtask

    task automatic step(input logic e, input logic ld,
                        input logic [15:0] d, input logic [3:0] dm);
        exp_t x;
        int   ph;
        int   sl;
        logic bnd;
        en      = e;
        load    = ld;
        data    = d;
        dp_mask = dm;
        ph  = phase_now();
        sl  = slot_now();
        bnd = e && (ph == DIV - 1) && (sl == 3);
        x   = '{ds: 2'd0, an: 4'hF, seg: 7'h7F, dp: 1'b1, pend: 1'b0, tick: 1'b0};
        if (e) begin
            x.ds   = 2'(sl);
            x.tick = bnd;
            if (ph >= DEAD) begin
                x.an[sl] = 1'b0;
                x.seg    = font_tb[4'((m_shadow >> (4 * sl)) & 16'hF)];
`ifdef SEG7_LZ_BLANK_EN
                if (sl != 0 && (m_shadow >> (4 * sl)) == 16'd0) x.seg = 7'h7F;
`endif
                x.dp = ~dm[sl];
            end
        end
        if (bnd) begin
            if (ld) m_shadow = d;
            else if (m_pending) m_shadow = m_pend;
            m_pending = 1'b0;
        end else if (ld) begin
            m_pend    = d;
            m_pending = 1'b1;
        end
        x.pend = m_pending;
        m_t    = e ? m_t + 1 : 0;
        q.push_back(x);
        pushed++;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] dm);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), dm);
    endtask

    task automatic check_reset_state(input string name);
        exp_t o;
        exp_t r;
        o = observed();
        r = '{ds: 2'd0, an: 4'hF, seg: 7'h7F, dp: 1'b1, pend: 1'b0, tick: 1'b0};
        checks++;
        if (o !== r) begin
            errors++;
            $display("FAIL %s got an=%b seg=%b dp=%b pend=%b tick=%b ds=%0d expected reset values",
                     name, o.an, o.seg, o.dp, o.pend, o.tick, o.ds);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        data    = 16'd0;
        dp_mask = 4'd0;
        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Plain scan, blank word displays 0 everywhere.
        idle(40, 4'd0);

        // Deferred load issued during slot 1.
        for (int i = 0; i < 64 && slot_now() != 1; i++) idle(1, 4'd0);
        step(1'b1, 1'b1, 16'h1F80, 4'd0);
        idle(70, 4'd0);

        // Older pending word is overridden by a load on the boundary.
        step(1'b1, 1'b1, 16'h1111, 4'd0);
        for (int i = 0; i < 64 && !(slot_now() == 3 && phase_now() == DIV - 1); i++)
            idle(1, 4'd0);
        step(1'b1, 1'b1, 16'h2222, 4'd0);
        idle(34, 4'd0);

        // Decimal point on digit 2 only.
        idle(34, 4'b0100);

        // Disable mid slot 2, load while disabled, then resume.
        for (int i = 0; i < 64 && !(slot_now() == 2 && phase_now() == 4); i++)
            idle(1, 4'd0);
        step(1'b0, 1'b0, 16'd0, 4'hF);
        step(1'b0, 1'b1, 16'hABCD, 4'hF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'($urandom), 4'hF);
        idle(70, 4'hF);

        // Leading-zero word.
        step(1'b1, 1'b1, 16'h0050, 4'd0);
        idle(70, 4'd0);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
                 16'($urandom), 4'($urandom));
        end
        idle(40, 4'd0);

        // Asynchronous reset mid-frame with a word pending.
        idle(5, 4'd0);
        step(1'b1, 1'b1, 16'h9876, 4'd0);
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(40, 4'd0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain got popped=%0d left=%0d expected popped=%0d left=0",
                     popped, q.size(), pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
